// File: rtl/grn_pkg.sv
// Shared types and constants for the grn result collector.
// No logic beyond the pair-pack helper.
// No flow control here.
package grn_pkg;

  localparam int PAIR_W         = 64;
  localparam int LINE_W         = 512;
  localparam int PAIRS_PER_LINE = 8;
  localparam int SLOT_W         = 4;   // holds 0..PAIRS_PER_LINE

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } t_out_state;

  // Transient length in the low word, low word of the configuration above it.
  function automatic logic [PAIR_W-1:0] pack_pair(input logic [31:0] conf_lo,
                                                  input logic [31:0] transient);
    return {conf_lo, transient};
  endfunction

endpackage

// File: rtl/grn_result_arbiter_if.sv
// Block-side request bus and host-side line bus of the grn result collector.
// Pure wiring, no latency.
// line_valid/line_ready carry the host backpressure; req is held until grant.
interface grn_result_arbiter_if
  import grn_pkg::*;
#(
  parameter int BLOCKS_NUMBER = 16,
  parameter int VECTOR_SIZE   = 69
);

  logic [BLOCKS_NUMBER-1:0]                  req;
  logic [BLOCKS_NUMBER-1:0][31:0]            transient_in;
  logic [BLOCKS_NUMBER-1:0][VECTOR_SIZE-1:0] conf_in;
  logic [BLOCKS_NUMBER-1:0]                  grant;
  logic                                      flush;
  logic                                      flush_done;
  logic                                      line_valid;
  logic                                      line_ready;
  logic [LINE_W-1:0]                         line_data;
  logic [3:0]                                line_pairs;
  logic [31:0]                               lines_sent;

  // Driven by the blocks and the host.
  modport master (
    output req, transient_in, conf_in, flush, line_ready,
    input  grant, flush_done, line_valid, line_data, line_pairs, lines_sent
  );

  // Driven by the collector.
  modport slave (
    input  req, transient_in, conf_in, flush, line_ready,
    output grant, flush_done, line_valid, line_data, line_pairs, lines_sent
  );

endinterface

// File: rtl/grn_rr_arbiter.sv
// Round-robin pick: first index of req & ~mask at or after ptr, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the pick is used.
module grn_rr_arbiter #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any
);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // Scan N positions starting at ptr; the first eligible one wins.
  always_comb begin : p_pick
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    o_winner = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!o_any && w_elig[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/grn_result_arbiter.sv
// Round-robin collector packing {conf,transient} pairs of grn blocks into 512-bit lines.
// req at edge t -> grant in cycle t+1; 8th capture at edge t -> line_valid after edge t+1.
// Fill/output double buffer; grants stall only when the fill is full and the output is held.
module grn_result_arbiter
  import grn_pkg::*;
#(
  parameter int BLOCKS_NUMBER = 16,
  parameter int VECTOR_SIZE   = 69
) (
  input logic                 clk,
  input logic                 rst_n,
  grn_result_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(BLOCKS_NUMBER);

  logic [BLOCKS_NUMBER-1:0]                 r_grant;
  logic [IDX_W-1:0]                         r_ptr;
  logic [SLOT_W-1:0]                        r_slot;
  logic [PAIRS_PER_LINE-1:0][PAIR_W-1:0]    r_fill;
  logic [LINE_W-1:0]                        r_out_data;
  logic [3:0]                               r_out_pairs;
  logic [31:0]                              r_lines_sent;
  logic                                     r_flush_pending;
  logic                                     r_flush_done;
  t_out_state                               r_state;
  t_out_state                               w_state_nxt;

  logic [IDX_W-1:0]  w_winner;
  logic              w_any;
  logic              w_full;
  logic              w_accept;
  logic              w_out_free;
  logic              w_move;
  logic              w_cap_en;
  logic              w_cap;
  logic [2:0]        w_cap_slot;
  logic [PAIR_W-1:0] w_pair;
  logic [IDX_W:0]    w_ptr_sum;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic              w_done;
  logic [LINE_W-1:0] w_line;

  // The registered grant doubles as the mask, so a block still holding req
  // during its grant cycle cannot be captured a second time.
  grn_rr_arbiter #(
    .N     (BLOCKS_NUMBER),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req    (bus.req),
    .i_mask   (r_grant),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_full     = (r_slot == SLOT_W'(PAIRS_PER_LINE));
  assign w_accept   = (r_state == OUT_VALID) && bus.line_ready;
  assign w_out_free = (r_state == OUT_EMPTY) || w_accept;
  assign w_move     = (w_full || (r_flush_pending && (r_slot != '0))) && w_out_free;
  // A move frees the fill buffer on the same edge, so capture keeps full rate.
  assign w_cap_en   = !r_flush_pending && (!w_full || w_move);
  assign w_cap      = w_cap_en && w_any;
  assign w_cap_slot = w_move ? 3'd0 : r_slot[2:0];
  assign w_pair     = pack_pair(bus.conf_in[w_winner][31:0], bus.transient_in[w_winner]);
  assign w_ptr_sum  = {1'b0, w_winner} + (IDX_W+1)'(1);
  assign w_ptr_nxt  = (w_ptr_sum == (IDX_W+1)'(BLOCKS_NUMBER)) ? '0 : w_ptr_sum[IDX_W-1:0];
  assign w_done     = r_flush_pending && (r_slot == '0) && (r_state == OUT_EMPTY);

  // Assemble the outgoing line; slots beyond the fill count read as zero.
  always_comb begin
    w_line = '0;
    for (int k = 0; k < PAIRS_PER_LINE; k++) begin
      w_line[k*PAIR_W +: PAIR_W] = (SLOT_W'(k) < r_slot) ? r_fill[k] : '0;
    end
  end

  // Arbitration result: grant pulse, round-robin pointer, fill buffer and slot count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_ptr   <= '0;
      r_slot  <= '0;
      r_fill  <= '0;
    end else begin
      r_grant <= w_cap ? (BLOCKS_NUMBER'(1) << w_winner) : '0;
      if (w_cap) begin
        r_fill[w_cap_slot] <= w_pair;
        r_ptr              <= w_ptr_nxt;
      end
      if (w_move) begin
        r_slot <= w_cap ? SLOT_W'(1) : '0;
      end else if (w_cap) begin
        r_slot <= r_slot + SLOT_W'(1);
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output FSM next state: a move always leaves a line waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_move) w_state_nxt = OUT_VALID;
      OUT_VALID: if (w_accept && !w_move) w_state_nxt = OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  // Output line register and accepted-line counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_pairs  <= '0;
      r_lines_sent <= '0;
    end else begin
      if (w_move) begin
        r_out_data  <= w_line;
        r_out_pairs <= r_slot;
      end
      if (w_accept) begin
        r_lines_sent <= r_lines_sent + 32'd1;
      end
    end
  end

  // Flush bookkeeping: a new flush is ignored until the pending one reports done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pending <= 1'b0;
      r_flush_done    <= 1'b0;
    end else begin
      r_flush_done <= w_done;
      if (w_done) begin
        r_flush_pending <= 1'b0;
      end else if (bus.flush) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  assign bus.grant      = r_grant;
  assign bus.flush_done = r_flush_done;
  assign bus.line_valid = (r_state == OUT_VALID);
  assign bus.line_data  = r_out_data;
  assign bus.line_pairs = r_out_pairs;
  assign bus.lines_sent = r_lines_sent;

endmodule

// File: tb/tb_grn_result_arbiter.sv
// Directed bench for grn_result_arbiter with a grant/pair/line scoreboard.
// Expected grants and pairs are queued at stimulus time, popped by a monitor.
// Host backpressure is driven by the sequence through line_ready.
module tb_grn_result_arbiter;
  import grn_pkg::*;

  localparam int NB = 16;
  localparam int VS = 69;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  grn_result_arbiter_if #(.BLOCKS_NUMBER(NB), .VECTOR_SIZE(VS)) bus ();

  grn_result_arbiter #(.BLOCKS_NUMBER(NB), .VECTOR_SIZE(VS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          q_grant[$];
  logic [63:0] q_pair[$];
  int          q_lp[$];

  int            cyc      = 0;
  int            acc_cyc  = -10;
  int            n_grants = 0;
  logic [NB-1:0] req_v     = '0;
  logic [NB-1:0] hold_mask = '0;

  logic [NB-1:0] prev_grant = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [511:0]  prev_data  = '0;
  logic [3:0]    prev_pairs = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tr_of(input int i, input logic [7:0] s);
    return {s, 8'hA5, 8'h00, 8'(i)};
  endfunction

  function automatic logic [31:0] cf_of(input int i, input logic [7:0] s);
    return {8'hC3, s, 8'h5A, 8'(i)};
  endfunction

  task automatic set_data(input logic [7:0] s);
    for (int i = 0; i < NB; i++) begin
      bus.transient_in[i] = tr_of(i, s);
      bus.conf_in[i]      = {37'h15_5555_5555, cf_of(i, s)};
    end
  endtask

  task automatic push_block(input int i, input logic [7:0] s);
    q_grant.push_back(i);
    q_pair.push_back({cf_of(i, s), tr_of(i, s)});
  endtask

  // One clock; requesters drop req once granted unless listed in hold_mask.
  task automatic step();
    logic acc;
    acc = bus.line_valid && bus.line_ready;
    @(posedge clk);
    cyc++;
    if (acc) acc_cyc = cyc;
    #1;
    n_grants += $countones(bus.grant);
    req_v = (req_v & ~bus.grant) | (bus.grant & hold_mask);
    bus.req = req_v;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_grant"}, 64'(bus.grant), 64'd0);
    chk({tag, "_fdone"}, 64'(bus.flush_done), 64'd0);
    chk({tag, "_valid"}, 64'(bus.line_valid), 64'd0);
    chk({tag, "_pairs"}, 64'(bus.line_pairs), 64'd0);
    chk({tag, "_sent"},  64'(bus.lines_sent), 64'd0);
    chk({tag, "_data_zero"}, 64'(bus.line_data == '0), 64'd1);
  endtask

  // Assert reset away from the clock edge, check outputs at once, release later.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(tag);
    q_grant.delete();
    q_pair.delete();
    q_lp.delete();
    req_v     = '0;
    hold_mask = '0;
    bus.req   = '0;
    bus.flush = 1'b0;
    n_grants  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.grant != '0) begin
        chk("grant_onehot", 64'($onehot(bus.grant)), 64'd1);
        chk("grant_twice", 64'(bus.grant & prev_grant), 64'd0);
        if (q_grant.size() == 0) begin
          chk("grant_unexpected", 64'(bus.grant), 64'd0);
        end else begin
          chk("grant_idx", 64'(bus.grant), 64'(NB'(1) << q_grant.pop_front()));
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 64'(bus.line_valid), 64'd1);
        chk("hold_data", 64'(bus.line_data == prev_data), 64'd1);
        chk("hold_pairs", 64'(bus.line_pairs), 64'(prev_pairs));
      end
      if (bus.line_valid && bus.line_ready) begin
        if (q_lp.size() == 0) begin
          chk("line_unexpected", 64'(bus.line_pairs), 64'd0);
        end else begin
          int lp;
          lp = q_lp.pop_front();
          chk("line_pairs", 64'(bus.line_pairs), 64'(lp));
          for (int k = 0; k < 8; k++) begin
            logic [63:0] e;
            e = '0;
            if (k < lp && q_pair.size() != 0) e = q_pair.pop_front();
            chk($sformatf("line_slot%0d", k), bus.line_data[k*64 +: 64], e);
          end
        end
      end
      prev_grant = bus.grant;
      prev_valid = bus.line_valid;
      prev_ready = bus.line_ready;
      prev_data  = bus.line_data;
      prev_pairs = bus.line_pairs;
    end else begin
      prev_grant = '0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first_g;
    int last_g;
    logic got;
    int done_cyc;

    bus.req        = '0;
    bus.flush      = 1'b0;
    bus.line_ready = 1'b0;
    set_data(8'h11);
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    rst_n = 1'b1;

    // 1: all 16 request, host always ready -> 0..15 in order, two full lines.
    do_reset("rst1");
    set_data(8'h11);
    for (int i = 0; i < NB; i++) push_block(i, 8'h11);
    q_lp.push_back(8);
    q_lp.push_back(8);
    bus.line_ready = 1'b1;
    req_v   = '1;
    bus.req = req_v;
    for (k = 0; k < 60; k++) begin
      step();
      if (q_lp.size() == 0) break;
    end
    step();
    chk("t1_lines_left", 64'(q_lp.size()), 64'd0);
    chk("t1_grants_left", 64'(q_grant.size()), 64'd0);
    chk("t1_lines_sent", 64'(bus.lines_sent), 64'd2);
    chk("t1_valid_idle", 64'(bus.line_valid), 64'd0);

    // 2: block 3 alone, holding req through each grant -> every 2nd cycle, no double capture.
    do_reset("rst2");
    set_data(8'h22);
    for (int i = 0; i < 8; i++) push_block(3, 8'h22);
    q_lp.push_back(8);
    bus.line_ready = 1'b1;
    hold_mask = NB'(1) << 3;
    req_v     = NB'(1) << 3;
    bus.req   = req_v;
    first_g = -1;
    last_g  = -1;
    for (k = 0; k < 40; k++) begin
      step();
      if (bus.grant[3] && first_g < 0) first_g = cyc;
      if (n_grants == 8) begin
        last_g = cyc;
        break;
      end
    end
    hold_mask = '0;
    req_v     = '0;
    bus.req   = '0;
    chk("t2_grant_span", 64'(last_g - first_g), 64'd14);
    for (k = 0; k < 20; k++) begin
      step();
      if (q_lp.size() == 0) break;
    end
    step();
    chk("t2_lines_left", 64'(q_lp.size()), 64'd0);
    chk("t2_lines_sent", 64'(bus.lines_sent), 64'd1);

    // 3: host stalled -> second line fills, grants stop, release drains in order.
    do_reset("rst3");
    set_data(8'h33);
    for (int i = 0; i < NB; i++) push_block(i, 8'h33);
    push_block(5, 8'h33);
    q_lp.push_back(8);
    q_lp.push_back(8);
    q_lp.push_back(1);
    bus.line_ready = 1'b0;
    req_v   = '1;
    bus.req = req_v;
    for (k = 0; k < 40; k++) begin
      step();
      if (n_grants == 16) break;
    end
    chk("t3_fill_grants", 64'(n_grants), 64'd16);
    req_v[5] = 1'b1;
    bus.req  = req_v;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_stall_grant", 64'(bus.grant), 64'd0);
      chk("t3_stall_valid", 64'(bus.line_valid), 64'd1);
    end
    chk("t3_stall_sent", 64'(bus.lines_sent), 64'd0);
    bus.line_ready = 1'b1;
    for (k = 0; k < 10; k++) begin
      step();
      if (n_grants == 17) break;
    end
    chk("t3_resume_grants", 64'(n_grants), 64'd17);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    got = 1'b0;
    for (k = 0; k < 30; k++) begin
      step();
      if (bus.flush_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("t3_flush_done", 64'(got), 64'd1);
    chk("t3_lines_left", 64'(q_lp.size()), 64'd0);
    chk("t3_lines_sent", 64'(bus.lines_sent), 64'd3);

    // 4: three captures then flush -> 3-pair line, done 1 cycle after acceptance.
    do_reset("rst4");
    set_data(8'h44);
    for (int i = 0; i < 3; i++) push_block(i, 8'h44);
    q_lp.push_back(3);
    bus.line_ready = 1'b1;
    req_v   = NB'(7);
    bus.req = req_v;
    for (k = 0; k < 20; k++) begin
      step();
      if (n_grants == 3) break;
    end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    req_v[7]  = 1'b1;
    bus.req   = req_v;
    got      = 1'b0;
    done_cyc = -1;
    for (k = 0; k < 30; k++) begin
      step();
      if (bus.flush_done) begin
        got      = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    chk("t4_flush_done", 64'(got), 64'd1);
    chk("t4_done_after_accept", 64'(done_cyc - acc_cyc), 64'd1);
    chk("t4_lines_left", 64'(q_lp.size()), 64'd0);
    chk("t4_lines_sent", 64'(bus.lines_sent), 64'd1);
    push_block(7, 8'h44);
    step();
    step();
    chk("t4_resume_grant", 64'(q_grant.size()), 64'd0);

    // 5: flush with nothing buffered -> flush_done one cycle later, no line.
    do_reset("rst5");
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t5_done_early", 64'(bus.flush_done), 64'd0);
    step();
    chk("t5_done", 64'(bus.flush_done), 64'd1);
    chk("t5_no_line", 64'(bus.line_valid), 64'd0);
    step();
    chk("t5_done_pulse", 64'(bus.flush_done), 64'd0);
    chk("t5_no_line2", 64'(bus.line_valid), 64'd0);

    // 6: reset while a line is waiting, then arbitration restarts at block 0.
    set_data(8'h66);
    bus.line_ready = 1'b0;
    for (int i = 0; i < NB; i++) push_block(i, 8'h66);
    req_v   = '1;
    bus.req = req_v;
    for (k = 0; k < 20; k++) begin
      step();
      if (bus.line_valid) break;
    end
    chk("t6_valid_before", 64'(bus.line_valid), 64'd1);
    do_reset("rst6");
    set_data(8'h67);
    for (int i = 0; i < 8; i++) push_block(i, 8'h67);
    q_lp.push_back(8);
    bus.line_ready = 1'b1;
    req_v   = '1;
    bus.req = req_v;
    for (k = 0; k < 20; k++) begin
      step();
      if (n_grants == 8) break;
    end
    req_v   = '0;
    bus.req = '0;
    for (k = 0; k < 20; k++) begin
      step();
      if (q_lp.size() == 0) break;
    end
    step();
    chk("t6_lines_left", 64'(q_lp.size()), 64'd0);
    chk("t6_lines_sent", 64'(bus.lines_sent), 64'd1);
    chk("t6_grants_left", 64'(q_grant.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grn_result_arbiter.md
# grn_result_arbiter

Round-robin collector that sits between the BLOCKS_NUMBER grn simulation blocks and the host write path. Arbitrates among blocks signalling a finished trajectory, grants one per cycle, and packs each winner's {conf, transient} pair into 512-bit lines. Lines are double-buffered and emitted over a valid/ready handshake; a flush command drains a partial line.

## Interface
- BLOCKS_NUMBER, 16, number of grn requesters (2..32)
- VECTOR_SIZE, 69, width of conf_in; low 32 bits packed
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  BLOCKS_NUMBER  per-block result ready, held until granted
- transient_in  in  BLOCKS_NUMBER x 32  per-block transient length
- conf_in  in  BLOCKS_NUMBER x VECTOR_SIZE  per-block final configuration
- grant  out  BLOCKS_NUMBER  registered one-hot, one-cycle pulse per capture
- flush  in  1  single-cycle pulse: emit the partial line, then report
- flush_done  out  1  one-cycle pulse after the flush fully drains
- line_valid  out  1  line_data valid
- line_ready  in  1  consumer accepts the line
- line_data  out  512  packed line; pair k at bits [64k +: 64]
- line_pairs  out  4  valid pairs in line_data (1..8)
- lines_sent  out  32  count of accepted lines, wraps at 2^32

## Operation
- Pair format: {conf_in[i][31:0], transient_in[i]}; transient in bits [31:0], conf in [63:32].
- Arbitration, every cycle with capture enabled:
  - eligible = req AND NOT grant.
  - Pick the first eligible index at or after ptr, wrapping.
  - Register grant[winner]=1 and write the pair into fill slot `slot`; slot++.
  - Next ptr is (winner+1) mod BLOCKS_NUMBER.
- Masking with grant stops a requester that still holds req in its grant cycle from being captured twice.
- Capture is enabled when slot<8 and no flush is pending.
- Fill buffer full (slot==8), or flush pending with slot>0:
  - if the output register is empty, or is being accepted on this edge, move fill to output;
  - line_pairs = slot; unused slots are zero; slot returns to 0.
- The move edge also accepts a new capture into slot 0 (full rate).
- Output FSM:
  - OUT_EMPTY -> OUT_VALID on a move.
  - OUT_VALID -> OUT_EMPTY on line_valid & line_ready with no simultaneous move; lines_sent++.
  - If a move coincides with acceptance, stay in OUT_VALID with the new line; lines_sent++.
- Flush:
  - flush sets flush_pending; further grants are suppressed.
  - When slot==0 and the output is in OUT_EMPTY, pulse flush_done and clear flush_pending.
  - flush while already pending is ignored.
  - flush with nothing buffered gives flush_done 1 cycle later.

## Timing
- Reset values:
  - grant=0, flush_done=0, line_valid=0, line_data=0, line_pairs=0, lines_sent=0;
  - ptr=0, slot=0, flush_pending=0, output state OUT_EMPTY.
- req sampled at edge t gives grant during cycle t+1. The requester drops req by edge t+2.
- Throughput: one capture per cycle across distinct blocks. The same block is captured at most every 2 cycles.
- 8th capture at edge t gives line_valid at edge t+1, if the output is free.
- line_valid and line_data hold steady until accepted; line_ready is ignored while line_valid=0.
- Backpressure stall: grants stop while slot==8 and the output is occupied. No pair is ever dropped or overwritten.
- rst_n asserted mid-operation: every register clears at once, buffered pairs are lost, grant drops the same cycle.

## Structure
- Package grn_pkg:
  - PAIR_W=64, LINE_W=512, PAIRS_PER_LINE=8;
  - t_out_state enum {OUT_EMPTY, OUT_VALID};
  - pair-pack function.
- Sub-module grn_rr_arbiter: combinational pick of req & ~mask from ptr, returns winner index and any-valid.
- Top holds the fill/output buffers, counters and the flush logic.

## Test plan
- All 16 req high, held until granted, line_ready=1 -> grants 0,1,…,7 then 8…15 in order; two lines, line_pairs=8; lines_sent=2; pair k of line 0 holds block k's values.
- Only block 3 requests, re-asserting 1 cycle after each grant, 8 times -> grants at most every 2 cycles; no double capture; one line.
- line_ready=0 with 16 requests continuously -> first line held steady; second line fills; grants stop at slot 8; release gives 2 lines in order, none lost.
- Capture 3 pairs, then flush -> line with line_pairs=3 and slots 3..7 zero; flush_done 1 cycle after acceptance; req during pending not granted.
- flush while empty -> flush_done the next cycle; no line_valid.
- rst_n low mid-line with line_valid=1 -> all outputs reach reset values asynchronously; after release, arbitration restarts at block 0.
